// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit and its helpers.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        MD_BUSY   = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that beats the increment.
module sat_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit_ms.sv
// Pipeline hazard control: multi-cycle load-use stall, mul/div EX hold with
// watchdog, taken-branch flush, and saturating stall/flush counters.
module hazard_unit_ms
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_STALL = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_md_valid,
    input  logic                  md_done,
    input  logic                  branch_taken,
    input  logic                  cnt_clr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  md_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    if ((LOAD_STALL < 1) || (LOAD_STALL > 15)) begin : g_bad_load_stall
        $error("hazard_unit_ms: LOAD_STALL must be in 1..15");
    end

    // Wide enough to hold MD_TIMEOUT without wrapping before the compare fires.
    localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 2);

    state_e              state_q, state_d;
    logic [3:0]          ld_cnt_q, ld_cnt_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_to_q, md_to_d;
    logic                load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        md_cnt_d     = md_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (ex_md_valid && !md_done) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                    state_d      = MD_BUSY;
                    md_cnt_d     = MD_CNT_W'(1);
                end else if (branch_taken) begin
                    // The dependent instruction is squashed, so any load-use is moot.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d  = LOAD_WAIT;
                        ld_cnt_d = 4'(LOAD_STALL - 1);
                    end
                end
            end
            LOAD_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                ld_cnt_d    = ld_cnt_q - 4'd1;
                if (ld_cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            MD_BUSY: begin
                if (!md_done) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                    if (md_cnt_q != '1) begin
                        md_cnt_d = md_cnt_q + MD_CNT_W'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        md_to_d = md_to_q || ((MD_TIMEOUT != 0) && (state_q == MD_BUSY) &&
                              (md_cnt_q >= MD_CNT_W'(MD_TIMEOUT)));

        if (!rst_n) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
            md_to_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
            md_to_q  <= md_to_d;
        end
    end

    assign md_timeout = md_to_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (!pc_write),
        .clr_i  (cnt_clr),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (if_id_flush),
        .clr_i  (cnt_clr),
        .cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit_ms.sv
// Directed bench for hazard_unit_ms: two instances share stimulus, one with
// LOAD_STALL=1/MD_TIMEOUT=8/CNT_W=4 and one with LOAD_STALL=3/defaults.
module tb_hazard_unit_ms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_md_valid;
    logic       md_done, branch_taken, cnt_clr;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write;
    logic        a_id_ex_flush, a_ex_mem_flush, a_md_timeout;
    logic [3:0]  a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write;
    logic        b_id_ex_flush, b_ex_mem_flush, b_md_timeout;
    logic [31:0] b_stall_cnt, b_flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit_ms #(.REG_ADDR_W(5), .LOAD_STALL(1), .MD_TIMEOUT(8), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_md_valid(ex_md_valid), .md_done(md_done),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
        .id_ex_write(a_id_ex_write), .id_ex_flush(a_id_ex_flush),
        .ex_mem_flush(a_ex_mem_flush), .md_timeout(a_md_timeout),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_unit_ms #(.REG_ADDR_W(5), .LOAD_STALL(3), .MD_TIMEOUT(64), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_md_valid(ex_md_valid), .md_done(md_done),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
        .id_ex_write(b_id_ex_write), .id_ex_flush(b_id_ex_flush),
        .ex_mem_flush(b_ex_mem_flush), .md_timeout(b_md_timeout),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counters();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_md_valid = 1'b0; md_done = 1'b0; branch_taken = 1'b0; cnt_clr = 1'b0;

        // Reset forces default outputs even with a hazard present
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        check_eq("rst_pc_write", 64'(a_pc_write), 64'd1);
        check_eq("rst_id_ex_flush", 64'(b_id_ex_flush), 64'd0);
        step(); step();
        check_eq("rst_stall_cnt", 64'(a_stall_cnt), 64'd0);
        check_eq("rst_flush_cnt", 64'(b_flush_cnt), 64'd0);
        check_eq("rst_md_timeout", 64'(a_md_timeout), 64'd0);

        // Load-use: 1-cycle stall on A, 3-cycle stall on B
        rst_n = 1'b1;
        #1;
        check_eq("lu_a_pc_write", 64'(a_pc_write), 64'd0);
        check_eq("lu_a_id_ex_flush", 64'(a_id_ex_flush), 64'd1);
        check_eq("lu_a_if_id_write", 64'(a_if_id_write), 64'd0);
        check_eq("lu_a_id_ex_write", 64'(a_id_ex_write), 64'd1);
        check_eq("lu_b_pc_write_c1", 64'(b_pc_write), 64'd0);
        step();
        ex_mem_read = 1'b0;
        #1;
        check_eq("lu_a_release", 64'(a_pc_write), 64'd1);
        check_eq("lu_b_pc_write_c2", 64'(b_pc_write), 64'd0);
        check_eq("lu_b_id_ex_flush_c2", 64'(b_id_ex_flush), 64'd1);
        step();
        check_eq("lu_b_pc_write_c3", 64'(b_pc_write), 64'd0);
        step();
        check_eq("lu_b_release", 64'(b_pc_write), 64'd1);
        check_eq("lu_a_stall_cnt", 64'(a_stall_cnt), 64'd1);
        check_eq("lu_b_stall_cnt", 64'(b_stall_cnt), 64'd3);

        // x0 destination never hazards; unused source never hazards
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        check_eq("x0_a_pc_write", 64'(a_pc_write), 64'd1);
        check_eq("x0_b_pc_write", 64'(b_pc_write), 64'd1);
        step();
        check_eq("x0_b_stall_cnt", 64'(b_stall_cnt), 64'd3);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3; id_rs1_used = 1'b0;
        #1;
        check_eq("rs1_unused_pc_write", 64'(a_pc_write), 64'd1);
        id_rs1_used = 1'b1;
        #1;
        check_eq("rs1_used_pc_write", 64'(a_pc_write), 64'd0);
        step();
        ex_mem_read = 1'b0; id_rs1_used = 1'b0;
        step(); step();
        check_eq("rs1_b_release", 64'(b_pc_write), 64'd1);

        clr_counters();
        check_eq("clr_a_stall_cnt", 64'(a_stall_cnt), 64'd0);
        check_eq("clr_b_stall_cnt", 64'(b_stall_cnt), 64'd0);

        // Mul/div hold for 4 cycles, released in the md_done cycle
        ex_md_valid = 1'b1;
        #1;
        check_eq("md_a_pc_write_c1", 64'(a_pc_write), 64'd0);
        check_eq("md_a_id_ex_write_c1", 64'(a_id_ex_write), 64'd0);
        check_eq("md_a_ex_mem_flush_c1", 64'(a_ex_mem_flush), 64'd1);
        step();
        for (int i = 2; i <= 4; i++) begin
            check_eq("md_b_id_ex_write_hold", 64'(b_id_ex_write), 64'd0);
            check_eq("md_b_ex_mem_flush_hold", 64'(b_ex_mem_flush), 64'd1);
            step();
        end
        md_done = 1'b1;
        #1;
        check_eq("md_a_release_pc", 64'(a_pc_write), 64'd1);
        check_eq("md_a_release_id_ex", 64'(a_id_ex_write), 64'd1);
        check_eq("md_b_release_flush", 64'(b_ex_mem_flush), 64'd0);
        step();
        ex_md_valid = 1'b0; md_done = 1'b0;
        #1;
        check_eq("md_a_stall_cnt", 64'(a_stall_cnt), 64'd4);
        check_eq("md_b_stall_cnt", 64'(b_stall_cnt), 64'd4);
        check_eq("md_a_no_timeout", 64'(a_md_timeout), 64'd0);

        // Branch beats a simultaneous load-use
        clr_counters();
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        #1;
        check_eq("br_b_if_id_flush", 64'(b_if_id_flush), 64'd1);
        check_eq("br_b_id_ex_flush", 64'(b_id_ex_flush), 64'd1);
        check_eq("br_b_pc_write", 64'(b_pc_write), 64'd1);
        check_eq("br_a_if_id_write", 64'(a_if_id_write), 64'd1);
        step();
        branch_taken = 1'b0; ex_mem_read = 1'b0;
        #1;
        check_eq("br_b_flush_cnt", 64'(b_flush_cnt), 64'd1);
        check_eq("br_b_stall_cnt", 64'(b_stall_cnt), 64'd0);
        check_eq("br_a_flush_cnt", 64'(a_flush_cnt), 64'd1);
        check_eq("br_b_no_load_wait", 64'(b_pc_write), 64'd1);

        // Watchdog on A after 8 MD_BUSY cycles; counter saturation on A
        clr_counters();
        ex_md_valid = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            check_eq("to_a_before", 64'(a_md_timeout), 64'd0);
            step();
        end
        check_eq("to_a_set", 64'(a_md_timeout), 64'd1);
        for (int k = 0; k < 11; k++) step();
        check_eq("to_a_sticky", 64'(a_md_timeout), 64'd1);
        check_eq("to_a_still_hold", 64'(a_pc_write), 64'd0);
        check_eq("to_b_no_timeout", 64'(b_md_timeout), 64'd0);
        check_eq("sat_a_stall_cnt", 64'(a_stall_cnt), 64'd15);
        check_eq("sat_b_stall_cnt", 64'(b_stall_cnt), 64'd20);
        clr_counters();
        check_eq("sat_a_clr", 64'(a_stall_cnt), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("to_rst_pc_write", 64'(a_pc_write), 64'd1);
        step();
        rst_n = 1'b1; ex_md_valid = 1'b0;
        #1;
        check_eq("to_rst_md_timeout", 64'(a_md_timeout), 64'd0);
        check_eq("to_rst_a_run", 64'(a_pc_write), 64'd1);
        check_eq("to_rst_b_run", 64'(b_pc_write), 64'd1);

        // Reset in the middle of a multi-cycle load stall abandons it
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        step();
        ex_mem_read = 1'b0;
        #1;
        check_eq("lw_b_in_stall", 64'(b_pc_write), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("lw_rst_b_forced", 64'(b_pc_write), 64'd1);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("lw_rst_b_run", 64'(b_pc_write), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_ms.md
Name: hazard_unit_ms

Overview:
Second-generation hazard unit for the 5-stage RISC-V pipeline.
- Generalises load-use detection to a parametrised multi-cycle data-memory latency.
- Adds EX-stage hold for a multi-cycle mul/div unit, with watchdog timeout.
- Adds taken-branch flush control and saturating stall/flush performance counters.
- Sits beside the ID/EX pipeline registers and drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls.

Parameters:
REG_ADDR_W, 5, register-index width
LOAD_STALL, 1, stall cycles per load-use hazard (1..15)
MD_TIMEOUT, 64, max MD_BUSY cycles before md_timeout is set; 0 disables the watchdog
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
id_rs1_used, id_rs2_used  in  1  source operand actually read
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_md_valid  in  1  EX instruction is mul/div
md_done  in  1  mul/div result valid this cycle
branch_taken  in  1  EX resolved a taken branch or jump
cnt_clr  in  1  clear performance counters
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID becomes bubble
id_ex_write  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX becomes bubble
ex_mem_flush  out  1  EX/MEM becomes bubble
md_timeout  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Reset: all state changes only on the rising clk edge; rst_n is sampled at clk.
  - rst_n=0 → state RUN, load counter 0, md counter 0, md_timeout=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, outputs are forced to: pc_write=1, if_id_write=1, id_ex_write=1, all flushes=0.
  - Reset mid-stall abandons the stall immediately.
- Default outputs: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0, id_ex_flush=0, ex_mem_flush=0.
- load_use (combinational): ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)). Register x0 never creates a hazard.
- Outputs are combinational (Mealy) from state and inputs, so each action applies in the same cycle.
- FSM states: RUN, LOAD_WAIT, MD_BUSY.
- RUN, priority order:
  1. ex_md_valid && !md_done → pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1; next state MD_BUSY, md counter=1.
  2. branch_taken → if_id_flush=1, id_ex_flush=1, no stall. A simultaneous load_use is ignored because the dependent instruction is squashed.
  3. load_use → pc_write=0, if_id_write=0, id_ex_flush=1. If LOAD_STALL>1: next state LOAD_WAIT, load counter=LOAD_STALL-1. Otherwise stay in RUN.
- LOAD_WAIT:
  - Same stall outputs as load_use.
  - Load counter decrements each cycle; at counter==1 the next state is RUN.
  - branch_taken and load_use inputs are ignored, since EX holds a bubble.
  - Total stall for one hazard = exactly LOAD_STALL cycles.
- MD_BUSY:
  - md_done=0 → hold outputs as in RUN step 1; md counter increments.
  - md_done=1 → default outputs (release) this cycle; next state RUN.
  - If MD_TIMEOUT!=0 and md counter reaches MD_TIMEOUT, md_timeout is set. It is sticky until reset. The hold continues regardless.
- Counters:
  - stall_cnt increments on each cycle with pc_write=0; flush_cnt increments on each cycle with if_id_flush=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment: the counter loads 0 that cycle.
- LOAD_STALL outside 1..15 is an elaboration error.

Decomposition:
- Shared package hazard_pkg holds: the state enum (RUN=2'd0, LOAD_WAIT=2'd1, MD_BUSY=2'd2), the REG_ADDR_W default, and a ZERO_REG constant.
- Sub-module sat_counter (CNT_W, inc, clr) is instantiated twice for the performance counters.
- Hazard compare logic stays inline in hazard_unit_ms.

Test Plan:
1. LOAD_STALL=1: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → one cycle with pc_write=0, id_ex_flush=1; stall_cnt=1.
2. LOAD_STALL=3, same hazard → pc_write=0 for exactly 3 consecutive cycles, then 1; stall_cnt=3. Repeat with ex_rd=0 → no stall.
3. ex_md_valid=1, md_done arriving on the 5th cycle → hold asserted 4 cycles (id_ex_write=0, ex_mem_flush=1), released in the md_done cycle; stall_cnt=4.
4. branch_taken=1 simultaneous with load_use → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
5. MD_TIMEOUT=8, md_done never asserted → md_timeout rises after the 8th MD_BUSY cycle and stays high; rst_n=0 for one edge → state RUN, md_timeout=0.
6. CNT_W=4: hold 20 cycles → stall_cnt saturates at 15; cnt_clr=1 → 0 next cycle.
